freq_meter: RTL and testbench

//  Measures the frequency of an asynchronous input. Counts rising edges of sig_in over a

---
 rtl/freq_meter.sv | 125 ++++++++++++
 tb/tb_freq_meter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a window of
// GATE_CYCLES clk cycles and reports the saturating count with a one-cycle valid pulse.
module freq_meter #(
  parameter int GATE_CYCLES = 100000000,
  parameter int GATE_BITS   = 27,
  parameter int CNT_BITS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sig_in,
  input  logic                start,
  input  logic                continuous,
  output logic [CNT_BITS-1:0] count_out,
  output logic                valid,
  output logic                overflow,
  output logic                busy
);

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam logic [GATE_BITS-1:0] GATE_LAST = GATE_BITS'(GATE_CYCLES - 1);
  localparam logic [GATE_BITS-1:0] GATE_ONE  = GATE_BITS'(1);
  localparam logic [CNT_BITS-1:0]  CNT_MAX   = {CNT_BITS{1'b1}};
  localparam logic [CNT_BITS-1:0]  CNT_ZERO  = {CNT_BITS{1'b0}};

  state_t                 state_r, state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   edge_s;
  logic                   sat_s;
  logic                   inc_s;
  logic [GATE_BITS-1:0]   gate_r, gate_s;
  logic [CNT_BITS-1:0]    edge_cnt_r, edge_cnt_s;
  logic                   ovf_r, ovf_s;
  logic [CNT_BITS-1:0]    count_s;
  logic                   overflow_s;
  logic                   valid_s;

  // Metastability synchronizer followed by a delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign edge_s = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign sat_s  = (edge_cnt_r == CNT_MAX);
  // An edge arriving on a saturated counter is dropped and flagged instead
  assign inc_s  = edge_s & ~sat_s;

  // Next-state, window counters and result capture
  always_comb begin
    state_s    = state_r;
    gate_s     = gate_r;
    edge_cnt_s = edge_cnt_r;
    ovf_s      = ovf_r;
    count_s    = count_out;
    overflow_s = overflow;
    valid_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start || continuous) begin
          state_s    = MEASURE;
          gate_s     = {GATE_BITS{1'b0}};
          edge_cnt_s = CNT_ZERO;
          ovf_s      = 1'b0;
        end else begin
          state_s    = IDLE;
        end
      end
      MEASURE: begin
        if (gate_r == GATE_LAST) begin
          // The last window cycle's own edge is folded into the reported result
          count_s    = edge_cnt_r + {{(CNT_BITS-1){1'b0}}, inc_s};
          overflow_s = ovf_r | (edge_s & sat_s);
          valid_s    = 1'b1;
          gate_s     = {GATE_BITS{1'b0}};
          edge_cnt_s = CNT_ZERO;
          ovf_s      = 1'b0;
          state_s    = continuous ? MEASURE : IDLE;
        end else begin
          gate_s     = gate_r + GATE_ONE;
          edge_cnt_s = edge_cnt_r + {{(CNT_BITS-1){1'b0}}, inc_s};
          ovf_s      = ovf_r | (edge_s & sat_s);
          state_s    = MEASURE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      gate_r     <= {GATE_BITS{1'b0}};
      edge_cnt_r <= CNT_ZERO;
      ovf_r      <= 1'b0;
      count_out  <= CNT_ZERO;
      overflow   <= 1'b0;
      valid      <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      gate_r     <= gate_s;
      edge_cnt_r <= edge_cnt_s;
      ovf_r      <= ovf_s;
      count_out  <= count_s;
      overflow   <= overflow_s;
      valid      <= valid_s;
      busy       <= (state_s == MEASURE);
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: two instances (8-bit and 4-bit counters) share stimulus;
// expected counts come from rising transitions in a recorded history of sampled sig_in.
module tb_freq_meter;

  localparam int GC = 100;

  logic       clk = 1'b0;
  logic       rst;
  logic       sig_in;
  logic       start;
  logic       continuous;
  logic [7:0] cnt8;
  logic       v8, o8, b8;
  logic [3:0] cnt4;
  logic       v4, o4, b4;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   hist [0:19999];
  int   gen_mode;
  int   per;
  int   ph;
  logic hold_val;

  freq_meter #(.GATE_CYCLES(GC), .GATE_BITS(7), .CNT_BITS(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .count_out(cnt8), .valid(v8), .overflow(o8), .busy(b8)
  );

  freq_meter #(.GATE_CYCLES(GC), .GATE_BITS(7), .CNT_BITS(4), .SYNC_STAGES(2)) u_dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .continuous(continuous),
    .count_out(cnt4), .valid(v4), .overflow(o4), .busy(b4)
  );

  always #5 clk = ~clk;

  // Record what the DUT's first synchronizer flop captures at each rising edge
  always @(posedge clk) begin
    hist[cyc+1] <= sig_in;
    cyc         <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Edges seen during window cycle j are sig_in rises two samples late (sync + prev flop)
  function automatic int raw_edges(input int k0);
    int n = 0;
    for (int j = 0; j < GC; j++)
      if (hist[k0+j-1] && !hist[k0+j-2]) n++;
    return n;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_v8"}, 32'(v8), 32'd0);
    chk({tag, "_b8"}, 32'(b8), 32'd0);
    chk({tag, "_v4"}, 32'(v4), 32'd0);
  endtask

  task automatic open_single(output int k0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k0 = cyc;
    chk("open_busy", 32'(b8), 32'd1);
  endtask

  // Caller is at the negedge just after window start k0 was sampled
  task automatic run_window(input int k0, input bit cont_after, input bit poke,
                            input int drop_at, input int fix8, input int fix4);
    int raw;
    int e4;
    for (int j = 1; j < GC; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && (j == 10 || j == 50 || j == 99)) start = 1'b1;
      if (j == drop_at) continuous = 1'b0;
      chk("win_busy", 32'(b8), 32'd1);
      chk("win_valid8", 32'(v8), 32'd0);
      chk("win_valid4", 32'(v4), 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    raw = raw_edges(k0);
    e4  = (raw > 15) ? 15 : raw;
    chk("end_valid8", 32'(v8), 32'd1);
    chk("end_valid4", 32'(v4), 32'd1);
    chk("end_cnt8", 32'(cnt8), 32'(raw));
    chk("end_ovf8", 32'(o8), 32'(raw > 255));
    chk("end_cnt4", 32'(cnt4), 32'(e4));
    chk("end_ovf4", 32'(o4), 32'(raw > 15));
    chk("end_busy", 32'(b8), 32'(cont_after));
    if (fix8 >= 0) chk("spec_cnt8", 32'(cnt8), 32'(fix8));
    if (fix4 >= 0) chk("spec_cnt4", 32'(cnt4), 32'(fix4));
  endtask

  initial begin
    int k0;
    rst        = 1'b1;
    start      = 1'b0;
    continuous = 1'b0;
    sig_in     = 1'b0;
    gen_mode   = 1;
    per        = 2;
    ph         = 0;
    hold_val   = 1'b0;

    fork
      forever begin
        @(negedge clk);
        case (gen_mode)
          0: sig_in = hold_val;
          1: begin
            ph     = (ph >= per - 1) ? 0 : ph + 1;
            sig_in = (ph < per / 2);
          end
          default: sig_in = 1'($urandom_range(0, 1));
        endcase
      end
    join_none

    // 1: reset with sig_in toggling
    repeat (5) @(negedge clk);
    chk("rst_cnt8", 32'(cnt8), 32'd0);
    chk("rst_ovf8", 32'(o8), 32'd0);
    chk("rst_cnt4", 32'(cnt4), 32'd0);
    chk_idle("rst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk_idle("post_rst");

    // 2: single shot, period 10
    per = 10;
    repeat (3) @(negedge clk);
    open_single(k0);
    run_window(k0, 1'b0, 1'b0, -1, 10, 10);
    chk("t2_ovf4", 32'(o4), 32'd0);
    repeat (5) begin @(negedge clk); chk_idle("t2_after"); end

    // 3: continuous, period 4, then drop continuous mid-window
    per = 4;
    continuous = 1'b1;
    @(negedge clk);
    k0 = cyc;
    run_window(k0, 1'b1, 1'b0, -1, 25, 15);
    run_window(k0 + GC, 1'b1, 1'b0, -1, 25, 15);
    run_window(k0 + 2*GC, 1'b0, 1'b0, 50, 25, 15);
    repeat (5) begin @(negedge clk); chk_idle("t3_after"); end

    // 4: saturation of the 4-bit counter, then a clean window
    per = 2;
    repeat (3) @(negedge clk);
    open_single(k0);
    run_window(k0, 1'b0, 1'b0, -1, 50, 15);
    chk("t4_ovf4", 32'(o4), 32'd1);
    per = 20;
    repeat (4) @(negedge clk);
    open_single(k0);
    run_window(k0, 1'b0, 1'b0, -1, 5, 5);
    chk("t4b_ovf4", 32'(o4), 32'd0);

    // 5: starts inside an open window are ignored; sig_in held high counts nothing
    gen_mode = 0;
    hold_val = 1'b1;
    repeat (6) @(negedge clk);
    open_single(k0);
    run_window(k0, 1'b0, 1'b1, -1, 0, 0);
    repeat (20) begin @(negedge clk); chk_idle("t5_after"); end

    // 1b: reset in mid-window aborts it
    gen_mode = 1;
    per = 10;
    repeat (4) @(negedge clk);
    open_single(k0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mrst_cnt8", 32'(cnt8), 32'd0);
    chk("mrst_ovf8", 32'(o8), 32'd0);
    chk_idle("mrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (150) begin @(negedge clk); chk_idle("mrst_after"); end

    // Randomized windows against the history model
    for (int r = 0; r < 8; r++) begin
      gen_mode = $urandom_range(1, 2);
      per      = $urandom_range(2, 30);
      repeat ($urandom_range(3, 12)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        open_single(k0);
        run_window(k0, 1'b0, 1'b0, -1, -1, -1);
      end else begin
        continuous = 1'b1;
        @(negedge clk);
        k0 = cyc;
        run_window(k0, 1'b1, 1'b0, -1, -1, -1);
        run_window(k0 + GC, 1'b0, 1'b0, $urandom_range(1, 98), -1, -1);
      end
    end
    repeat (3) begin @(negedge clk); chk_idle("rand_after"); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
